sysid_probe_ctrl: RTL and testbench
===================================

# sysid_probe_ctrl

Avalon-MM master sequencer that reads the two-word system-ID slave (word 0 = system ID, word 1 = build timestamp), compares both against build-time expected values and publishes a sticky pass/fail status. Sits between the system-ID slave and the board bring-up/status logic, so a FPGA image can flag a hardware/software build mismatch without CPU involvement. Supports automatic probing after reset, software-triggered re-probe and a bounded wait on slave stall.

## Interface
- EXPECTED_ID, 32'd0: value required in word 0.
- EXPECTED_TS, 32'd1417892138: value required in word 1.
- TIMEOUT_CYCLES, 255: maximum cycles a read may stall on avm_waitrequest; range 1..65535.
- AUTO_START, 1: 1 = launch one probe automatically after reset release.

- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to (re)run the probe; ignored while busy.
- avm_address  out  1  word select to the system-ID slave (0 = ID, 1 = timestamp).
- avm_read  out  1  read strobe, held until accepted.
- avm_waitrequest  in  1  slave stall; tie 0 for zero-wait slaves.
- avm_readdata  in  32  slave read data, valid in the cycle read is accepted.
- busy  out  1  probe in progress.
- done  out  1  sticky: last probe finished (pass, fail or timeout).
- id_ok  out  1  sticky: captured ID equals EXPECTED_ID.
- ts_ok  out  1  sticky: captured timestamp equals EXPECTED_TS.
- timeout  out  1  sticky: a read stalled beyond TIMEOUT_CYCLES.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, FIN.
- IDLE: on start (or first cycle after reset release when AUTO_START=1) -> RD_ID; clear done, id_ok, ts_ok, timeout, stall counter; busy=1.
- RD_ID: avm_read=1, avm_address=0. Read accepted when avm_waitrequest=0: capture avm_readdata into id_value, clear stall counter, -> RD_TS.
- RD_TS: avm_read=1, avm_address=1. On accept capture ts_value -> CHECK.
- CHECK: id_ok = (id_value==EXPECTED_ID), ts_ok = (ts_value==EXPECTED_TS), full 32-bit compare -> FIN.
- FIN: done=1, busy=0 -> IDLE same cycle (FIN lasts one cycle); status held until next accepted start.
- Stall: 16-bit counter increments each cycle avm_read=1 and avm_waitrequest=1. When count reaches TIMEOUT_CYCLES with waitrequest still high: drop avm_read, set timeout=1, id_ok=ts_ok=0, -> FIN. Values captured before the timeout remain on id_value/ts_value; uncaptured word keeps its prior value.
- start while busy: ignored, no queuing. start in the FIN cycle: ignored; start in the following IDLE cycle: accepted.
- avm_address and avm_read are stable for the whole stalled read; avm_address=0 whenever avm_read=0.
- Reset mid-probe: all state and outputs return to reset values immediately; read strobe drops asynchronously; auto-probe reruns after release if AUTO_START=1.

## Timing
- Reset values: state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0.
- Zero-wait slave, start sampled high at edge N: RD_ID in cycle N+1, RD_TS N+2, CHECK N+3, FIN N+4 (done=1 and status valid from edge N+4, busy low from edge N+4). Total 4 cycles.
- AUTO_START: first edge with reset_n high acts as start edge N.
- Each stalled cycle on either read adds one cycle of latency; timeout asserted at edge where the counter equals TIMEOUT_CYCLES, FIN the next cycle.
- All outputs registered; no combinational path from avm_readdata/avm_waitrequest to any output.

## Test plan
- Zero-wait slave returning 0 / 1417892138, AUTO_START=1 -> done=1 four cycles after reset release, id_ok=1, ts_ok=1, timeout=0, reads at address 0 then 1.
- Slave returns 0 / 1417892139 -> id_ok=1, ts_ok=0, done=1, ts_value=1417892139.
- waitrequest high 3 cycles on each read -> pass, done 10 cycles after start; avm_address/avm_read stable during stalls.
- TIMEOUT_CYCLES=8, waitrequest stuck high on word 1 -> timeout=1, id_ok=ts_ok=0, avm_read drops, id_value captured, ts_value unchanged.
- start pulsed during RD_TS, then again after FIN -> first ignored, second reruns probe clearing prior status at start.
- reset_n low during RD_ID stall -> avm_read=0 and all status 0 immediately; after release, fresh probe completes and passes.

Source files
------------

// File: rtl/sysid_probe_ctrl_if.sv
// Avalon-MM read-only channel between the probe sequencer and the system-ID slave.
interface sysid_probe_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave  (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/sysid_probe_ctrl.sv
// Reads system ID and build timestamp from the sysid slave, compares them to the
// values baked into this image and publishes sticky pass/fail/timeout status.
module sysid_probe_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1417892138,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  sysid_probe_ctrl_if.master        avm,
  output logic                      busy,
  output logic                      done,
  output logic                      id_ok,
  output logic                      ts_ok,
  output logic                      timeout,
  output logic [31:0]               id_value,
  output logic [31:0]               ts_value
);
  localparam logic [15:0] TMO = TIMEOUT_CYCLES[15:0];

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, FIN} state_t;

  state_t      r_state, w_state;
  logic        r_read, w_read, r_addr, w_addr;
  logic        r_busy, w_busy, r_done, w_done;
  logic        r_id_ok, w_id_ok, r_ts_ok, w_ts_ok, r_tmo, w_tmo;
  logic        r_auto, w_auto;
  logic [15:0] r_cnt, w_cnt;
  logic [31:0] r_id, w_id, r_ts, w_ts;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
      r_addr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_id_ok <= 1'b0;
      r_ts_ok <= 1'b0;
      r_tmo   <= 1'b0;
      r_auto  <= AUTO_START;
      r_cnt   <= '0;
      r_id    <= '0;
      r_ts    <= '0;
    end else begin
      r_state <= w_state;
      r_read  <= w_read;
      r_addr  <= w_addr;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_id_ok <= w_id_ok;
      r_ts_ok <= w_ts_ok;
      r_tmo   <= w_tmo;
      r_auto  <= w_auto;
      r_cnt   <= w_cnt;
      r_id    <= w_id;
      r_ts    <= w_ts;
    end
  end

  always_comb begin
    w_state = r_state;
    w_busy  = r_busy;
    w_done  = r_done;
    w_id_ok = r_id_ok;
    w_ts_ok = r_ts_ok;
    w_tmo   = r_tmo;
    w_auto  = r_auto;
    w_cnt   = r_cnt;
    w_id    = r_id;
    w_ts    = r_ts;
    case (r_state)
      IDLE: begin
        // r_auto stands in for start on the first cycle out of reset
        if (start || r_auto) begin
          w_state = RD_ID;
          w_auto  = 1'b0;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_id_ok = 1'b0;
          w_ts_ok = 1'b0;
          w_tmo   = 1'b0;
          w_cnt   = '0;
        end
      end
      RD_ID, RD_TS: begin
        if (!avm.avm_waitrequest) begin
          w_cnt = '0;
          if (r_state == RD_ID) begin
            w_id    = avm.avm_readdata;
            w_state = RD_TS;
          end else begin
            w_ts    = avm.avm_readdata;
            w_state = CHECK;
          end
        end else if (r_cnt == TMO) begin
          w_tmo   = 1'b1;
          w_id_ok = 1'b0;
          w_ts_ok = 1'b0;
          w_state = FIN;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      CHECK: begin
        w_id_ok = (r_id == EXPECTED_ID);
        w_ts_ok = (r_ts == EXPECTED_TS);
        w_state = FIN;
      end
      FIN: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    // Strobe and address are registered from the next state so they never glitch
    w_read = (w_state == RD_ID) || (w_state == RD_TS);
    w_addr = (w_state == RD_TS);
  end

  assign avm.avm_read    = r_read;
  assign avm.avm_address = r_addr;
  assign busy            = r_busy;
  assign done            = r_done;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign timeout         = r_tmo;
  assign id_value        = r_id;
  assign ts_value        = r_ts;
endmodule

// File: tb/tb_sysid_probe_ctrl.sv
// Scoreboard bench: a stallable two-word slave model, expected probe results queued
// at launch and compared when done rises.
module tb_sysid_probe_ctrl;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1417892138;
  localparam int          T      = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_probe_ctrl_if avm();

  sysid_probe_ctrl #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [2];
  int          stall_id = 0, stall_ts = 0, scnt = 0, cyc = 0;
  logic        wr;

  assign wr = avm.avm_read && (scnt < (avm.avm_address ? stall_ts : stall_id));
  assign avm.avm_waitrequest = wr;
  assign avm.avm_readdata    = mem[avm.avm_address];

  always @(posedge clock or negedge reset_n)
    if (!reset_n) scnt <= 0;
    else if (wr)  scnt <= scnt + 1;
    else          scnt <= 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] idv, tsv;
    logic        idok, tsok, tmo;
    int          dcyc, nacc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_id = '0, m_ts = '0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Model of one probe launched with the current slave contents and stall settings
  task automatic push_exp();
    exp_t e;
    e.idok = 1'b0; e.tsok = 1'b0; e.tmo = 1'b0;
    if (stall_id > T) begin
      e.tmo = 1'b1; e.idv = m_id; e.tsv = m_ts; e.dcyc = cyc + T + 3; e.nacc = 0;
    end else if (stall_ts > T) begin
      m_id = mem[0];
      e.tmo = 1'b1; e.idv = m_id; e.tsv = m_ts; e.dcyc = cyc + T + 4 + stall_id; e.nacc = 1;
    end else begin
      m_id = mem[0]; m_ts = mem[1];
      e.idv = m_id; e.tsv = m_ts;
      e.idok = (m_id == EXP_ID); e.tsok = (m_ts == EXP_TS);
      e.dcyc = cyc + 5 + stall_id + stall_ts; e.nacc = 2;
    end
    q.push_back(e);
  endtask

  task automatic start_probe();
    @(negedge clock);
    push_exp();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clock);
    chk("wait_done", q.size(), 0);
  endtask

  logic       p_done = 1'b0, p_stall = 1'b0, p_read = 1'b0, p_addr = 1'b0;
  logic [1:0] acc_addr = '0;
  int         acc_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        acc_cnt = 0; acc_addr = '0; p_done = 1'b0; p_stall = 1'b0; p_read = 1'b0;
      end else begin
        if (p_stall && !timeout) chk("stall_hold", {avm.avm_read, avm.avm_address}, {1'b1, p_addr});
        if (p_read && !avm.avm_read) chk("addr_idle", avm.avm_address, 0);
        if (avm.avm_read && !wr) begin
          if (acc_cnt < 2) acc_addr[acc_cnt[0]] = avm.avm_address;
          acc_cnt++;
        end
        if (done && !p_done) begin
          if (q.size() == 0) chk("unexp_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("done_cyc", cyc, e.dcyc);
            chk("busy_fin", busy, 0);
            chk("id_ok", id_ok, e.idok);
            chk("ts_ok", ts_ok, e.tsok);
            chk("timeout", timeout, e.tmo);
            chk("id_value", id_value, e.idv);
            chk("ts_value", ts_value, e.tsv);
            chk("n_reads", acc_cnt, e.nacc);
            if (e.nacc == 2) chk("rd_order", acc_addr, 2'b10);
            if (e.nacc == 1) chk("rd_first", acc_addr[0], 0);
          end
          acc_cnt = 0; acc_addr = '0;
        end
        p_done  = done;
        p_stall = avm.avm_read && wr;
        p_read  = avm.avm_read;
        p_addr  = avm.avm_address;
      end
    end
  end

  initial begin
    mem[0] = EXP_ID;
    mem[1] = EXP_TS;
    repeat (3) @(negedge clock);
    chk("rst_read", avm.avm_read, 0);
    chk("rst_addr", avm.avm_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id_ok", id_ok, 0);
    chk("rst_ts_ok", ts_ok, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_idv", id_value, 0);
    chk("rst_tsv", ts_value, 0);

    // Auto probe after reset release, zero-wait slave, matching values
    @(negedge clock);
    push_exp();
    reset_n = 1'b1;
    wait_done();

    // Timestamp off by one
    mem[1] = EXP_TS + 32'd1;
    start_probe();
    wait_done();

    // Three stall cycles on each read
    mem[1] = EXP_TS; stall_id = 3; stall_ts = 3;
    start_probe();
    wait_done();

    // Timestamp read stuck: timeout, id captured, ts unchanged
    mem[0] = 32'hA5A5_0001; stall_id = 0; stall_ts = 1000;
    start_probe();
    wait_done();
    chk("tmo_read_low", avm.avm_read, 0);

    // start during RD_TS ignored; start after FIN reruns and clears status
    mem[0] = EXP_ID; mem[1] = EXP_TS + 32'd1; stall_ts = 0;
    start_probe();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clock);
    chk("no_rerun_busy", busy, 0);
    chk("no_rerun_done", done, 1);
    mem[1] = EXP_TS;
    start_probe();
    chk("clr_done", done, 0);
    chk("clr_id_ok", id_ok, 0);
    chk("clr_busy", busy, 1);
    wait_done();

    // Reset during a stalled ID read
    stall_id = 1000;
    start_probe();
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_read", avm.avm_read, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_id_ok", id_ok, 0);
    chk("arst_ts_ok", ts_ok, 0);
    chk("arst_tsv", ts_value, 0);
    q.delete();
    m_id = '0; m_ts = '0; stall_id = 0;
    @(negedge clock);
    push_exp();
    reset_n = 1'b1;
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
